mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory access sequencer for the multi-cycle CPU. Replaces the fixed single-cycle, 32-bit memory path with a request/acknowledge handshake toward memory, plus:
- configurable data and address width;
- byte and word accesses;
- run-time endian swap;
- alignment checking;
- a wait-state timeout.

It sits between the CPU control FSM (fetch, load, store) and the memory port, and serves one access at a time.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width; multiple of 8, at least 16. NB = DATA_WIDTH/8 byte lanes; LB = log2(NB).
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack; at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- little_endian_en  in  1  1: byte-reverse words on both read and write paths.
- req_valid  in  1  core requests an access.
- req_ready  out  1  unit is able to accept a request.
- req_write  in  1  1: store, 0: load.
- req_byte  in  1  1: byte access, 0: full-word access.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; bits [7:0] are used for a byte store.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  DATA_WIDTH  load result, valid with resp_valid.
- resp_error  out  1  qualifies resp_valid: access failed.
- mem_req  out  1  memory cycle active.
- mem_ack  in  1  memory completes the cycle.
- memory_addr  out  ADDR_WIDTH  word-aligned address (low LB bits are 0).
- data_to_memory  out  DATA_WIDTH  store data.
- mem_be  out  NB  byte-lane enables; bit i enables bits [8i+7:8i].
- write_to_memory  out  1  1: write, 0: read; meaningful only while mem_req is 1.
- data_from_memory  in  DATA_WIDTH  read data, sampled on the mem_ack cycle.
- memory_error  in  1  bus error, sampled while mem_req is 1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- req_ready = (state == IDLE).
- IDLE, on req_valid:
  - The request is captured (address, write, byte, wdata, little_endian_en).
  - Word access with req_addr[LB-1:0] != 0 is misaligned: go to RESP with resp_error=1 and no memory cycle.
  - Otherwise go to BUSY.
- BUSY:
  - mem_req=1 and all memory outputs are driven from the captured request.
  - Wait counter is cleared on entry and increments each BUSY cycle.
  - mem_ack=1 or memory_error=1: go to RESP.
  - Counter reaches TIMEOUT-1 with neither input asserted: go to RESP with resp_error=1.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
- Lane mapping:
  - Physical lane p holds bits [8p+7:8p].
  - Logical byte offset o = addr[LB-1:0].
  - Little-endian: p = o. Big-endian: p = NB-1-o.
- Word read: when little_endian_en=1, resp_rdata is data_from_memory byte-reversed (lane i to lane NB-1-i); otherwise it is unchanged.
- Word write: data_to_memory is req_wdata, byte-reversed when little_endian_en=1. mem_be is all ones.
- Byte write: req_wdata[7:0] is replicated to all lanes. mem_be has only bit p set.
- Byte read: resp_rdata = zero-extended data_from_memory lane p.
- Error responses always return resp_rdata = 0.
- Simultaneous events:
  - memory_error together with mem_ack: the error wins.
  - mem_ack on the timeout cycle: the ack wins and the access completes normally.
- req_valid outside IDLE is ignored; the core must hold the request until req_ready.
- rst low at any time, including mid-access: state goes to IDLE, the counter clears, and every output is forced to its reset value immediately. Any access in flight is dropped with no response.

## Timing
- Reset values:
  - req_ready=1 once rst is released.
  - resp_valid=0, resp_error=0, resp_rdata=0.
  - mem_req=0, memory_addr=0, data_to_memory=0, mem_be=0, write_to_memory=0.
- Request accepted at edge N:
  - mem_req is high in cycle N+1.
  - Ack sampled at edge N+1+k (k ≥ 0 wait cycles).
  - resp_valid is high in cycle N+2+k.
  - req_ready is high again in cycle N+3+k.
- Zero-wait access: 3 cycles from acceptance to the next acceptance.
- Misaligned access: resp_valid in cycle N+1; mem_req never rises.
- Timeout: mem_req is high for exactly TIMEOUT cycles; resp_valid with error follows in the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Word load, big-endian, default params, addr 0x100, memory returns 0x11223344 with 2 wait cycles:
  - mem_req is high for 3 cycles;
  - memory_addr = 0x100;
  - resp_rdata = 0x11223344 with resp_error=0.
- Same access with little_endian_en=1: resp_rdata = 0x44332211.
- Byte store, addr 0x103, req_wdata = 0xAB:
  - big-endian: mem_be = 0001, data_to_memory = 0xABABABAB, memory_addr = 0x100;
  - little-endian: mem_be = 1000.
- Byte load, addr 0x101, big-endian, memory word 0x11223344: resp_rdata = 0x00000022.
- Word load at addr 0x102: resp_error=1 one cycle after acceptance, and mem_req stays 0.
- Error and reset cases:
  - TIMEOUT=4 with mem_ack held low: mem_req is high for 4 cycles, then resp_error=1.
  - memory_error and mem_ack together: resp_error=1 and resp_rdata=0.
  - rst pulsed low mid-BUSY: all outputs return to reset values and no resp_valid is produced.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access sequencer between the CPU control FSM and the memory port: one
// request/acknowledge access at a time, byte/word, endian swap, alignment check, timeout.
//
// state | meaning
// IDLE  | ready to accept a core request
// BUSY  | memory cycle active, waiting for ack, bus error or timeout
// RESP  | one-cycle response to the core
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    little_endian_en,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_byte,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic [ADDR_WIDTH-1:0]   memory_addr,
    output logic [DATA_WIDTH-1:0]   data_to_memory,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    write_to_memory,
    input  logic [DATA_WIDTH-1:0]   data_from_memory,
    input  logic                    memory_error
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic                  byte_q;
    logic                  le_q;
    logic                  error_q;
    logic [CW-1:0]         wait_cnt;

    logic                  misaligned;
    logic                  timed_out;
    logic [LB-1:0]         lane;
    logic [NB-1:0]         lane_be;
    logic [DATA_WIDTH-1:0] wdata_word;
    logic [DATA_WIDTH-1:0] rdata_word;
    logic [DATA_WIDTH-1:0] rdata_byte;
    logic [DATA_WIDTH-1:0] rdata_val;

    function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = d[8*(NB-1-i) +: 8];
        return r;
    endfunction

    assign misaligned = !req_byte && (req_addr[LB-1:0] != '0);
    assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));
    // big-endian places logical byte 0 in the most significant lane
    assign lane       = le_q ? addr_q[LB-1:0] : LB'(NB - 1) - addr_q[LB-1:0];

    always_comb begin
        lane_be    = '0;
        rdata_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (lane == LB'(i)) begin
                lane_be[i]      = 1'b1;
                rdata_byte[7:0] = data_from_memory[8*i +: 8];
            end
        end
        wdata_word = le_q ? byte_swap(wdata_q) : wdata_q;
        rdata_word = le_q ? byte_swap(data_from_memory) : data_from_memory;
        rdata_val  = byte_q ? rdata_byte : rdata_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = misaligned ? RESP : BUSY;
            BUSY:    if (mem_ack || memory_error || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // response is resolved on the exit edge of BUSY so RESP only replays registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            le_q     <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        write_q  <= req_write;
                        byte_q   <= req_byte;
                        le_q     <= little_endian_en;
                        wait_cnt <= '0;
                        rdata_q  <= '0;
                        error_q  <= misaligned;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (memory_error) begin
                        error_q <= 1'b1;
                        rdata_q <= '0;
                    end else if (mem_ack) begin
                        error_q <= 1'b0;
                        rdata_q <= write_q ? '0 : rdata_val;
                    end else if (timed_out) begin
                        error_q <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready       = (state == IDLE);
        mem_req         = 1'b0;
        memory_addr     = '0;
        data_to_memory  = '0;
        mem_be          = '0;
        write_to_memory = 1'b0;
        resp_valid      = 1'b0;
        resp_error      = 1'b0;
        resp_rdata      = '0;
        case (state)
            BUSY: begin
                mem_req         = 1'b1;
                memory_addr     = {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                data_to_memory  = byte_q ? {NB{wdata_q[7:0]}} : wdata_word;
                mem_be          = byte_q ? lane_be : '1;
                write_to_memory = write_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = error_q;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level model predicts every output
// cycle by cycle; directed accesses pin the model with hand-computed literals.
module tb_mem_access_unit;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int K_ACK = 0, K_ERR = 1, K_ACKERR = 2, K_TO = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          little_endian_en = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic          req_byte = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] memory_addr;
    logic [DW-1:0] data_to_memory;
    logic [3:0]    mem_be;
    logic          write_to_memory;
    logic [DW-1:0] data_from_memory = '0;
    logic          memory_error = 1'b0;

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .little_endian_en(little_endian_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_req(mem_req), .mem_ack(mem_ack), .memory_addr(memory_addr),
        .data_to_memory(data_to_memory), .mem_be(mem_be), .write_to_memory(write_to_memory),
        .data_from_memory(data_from_memory), .memory_error(memory_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // expected outputs for the current cycle, written by the driver just after each edge
    logic        e_ready = 1'b1, e_rv = 1'b0, e_rerr = 1'b0, e_mreq = 1'b0, e_we = 1'b0;
    logic        e_chk_rd = 1'b0;
    logic [31:0] e_rd = '0, e_addr = '0, e_wd = '0;
    logic [3:0]  e_be = '0;
    bit          chk_en = 1'b0;

    // observation record, written only by the compare process
    int          mreq_total = 0;
    int          rv_total = 0;
    logic [31:0] last_addr = '0, last_wd = '0, last_rd = '0;
    logic [3:0]  last_be = '0;
    logic        last_err = 1'b0;

    int mreq0, rv0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, e_ready);
            check("resp_valid", resp_valid, e_rv);
            check("mem_req", mem_req, e_mreq);
            if (e_mreq) begin
                check("memory_addr", memory_addr, e_addr);
                check("write_to_memory", write_to_memory, e_we);
                if (e_we) begin
                    check("data_to_memory", data_to_memory, e_wd);
                    check("mem_be", mem_be, e_be);
                end
            end
            if (e_rv) begin
                check("resp_error", resp_error, e_rerr);
                if (e_chk_rd) check("resp_rdata", resp_rdata, e_rd);
            end
        end
        if (mem_req) begin
            mreq_total++;
            last_addr = memory_addr;
            last_wd   = data_to_memory;
            last_be   = mem_be;
        end
        if (resp_valid) begin
            rv_total++;
            last_rd  = resp_rdata;
            last_err = resp_error;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_ready = 1'b1; e_rv = 1'b0; e_mreq = 1'b0; e_chk_rd = 1'b0;
    endtask

    task automatic junk_mem();
        mem_ack          = 1'($urandom % 2);
        memory_error     = 1'($urandom % 2);
        data_from_memory = $urandom;
    endtask

    task automatic junk_req();
        req_valid        = 1'($urandom % 2);
        req_write        = 1'($urandom % 2);
        req_byte         = 1'($urandom % 2);
        req_addr         = $urandom;
        req_wdata        = $urandom;
        little_endian_en = 1'($urandom % 2);
    endtask

    // one complete access; kind picks how memory ends it, k is the number of wait cycles
    task automatic run_access(input bit w, input bit b, input logic [31:0] addr,
                              input logic [31:0] wd, input bit le, input int kind,
                              input int k, input logic [31:0] mw);
        int o, p, m;
        bit mis;
        o   = int'(addr[1:0]);
        p   = le ? o : 3 - o;
        mis = !b && (o != 0);
        set_idle();
        junk_mem();
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = addr;
        req_wdata = wd; little_endian_en = le;
        mreq0 = mreq_total;
        rv0   = rv_total;
        tick();
        if (mis) begin
            junk_req();
            junk_mem();
            e_ready = 1'b0; e_rv = 1'b1; e_rerr = 1'b1; e_chk_rd = 1'b1; e_rd = '0; e_mreq = 1'b0;
            tick();
        end else begin
            m = (kind == K_TO) ? TO - 1 : k;
            e_ready = 1'b0; e_rv = 1'b0; e_mreq = 1'b1;
            e_addr  = addr & ~32'h3;
            e_we    = w;
            e_wd    = b ? {4{wd[7:0]}} : (le ? swap32(wd) : wd);
            e_be    = b ? 4'(1 << p) : 4'hF;
            for (int j = 0; j <= m; j++) begin
                junk_req();
                mem_ack          = (j == k) && (kind == K_ACK || kind == K_ACKERR);
                memory_error     = (j == k) && (kind == K_ERR || kind == K_ACKERR);
                data_from_memory = (j == k) ? mw : $urandom;
                tick();
            end
            junk_req();
            junk_mem();
            e_mreq = 1'b0; e_rv = 1'b1;
            if (kind == K_ACK) begin
                e_rerr   = 1'b0;
                e_chk_rd = !w;
                e_rd     = b ? ((mw >> (8 * p)) & 32'hFF) : (le ? swap32(mw) : mw);
            end else begin
                e_rerr = 1'b1; e_chk_rd = 1'b1; e_rd = '0;
            end
            tick();
        end
        set_idle();
        req_valid = 1'b0;
        junk_mem();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1);
    end

    initial begin
        bit          w, b, le;
        logic [31:0] addr;
        int          kind, r, k, gap;

        set_idle();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        check("reset_req_ready", req_ready, 1);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_error", resp_error, 0);
        check("reset_resp_rdata", resp_rdata, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_memory_addr", memory_addr, 0);
        check("reset_data_to_memory", data_to_memory, 0);
        check("reset_mem_be", mem_be, 0);
        check("reset_write_to_memory", write_to_memory, 0);
        chk_en = 1'b1;

        run_access(0, 0, 32'h100, 32'h0, 0, K_ACK, 2, 32'h11223344);
        check("wl_be_mreq_cycles", mreq_total - mreq0, 3);
        check("wl_be_addr", last_addr, 32'h100);
        check("wl_be_rdata", last_rd, 32'h11223344);
        check("wl_be_err", last_err, 0);

        run_access(0, 0, 32'h100, 32'h0, 1, K_ACK, 2, 32'h11223344);
        check("wl_le_rdata", last_rd, 32'h44332211);

        run_access(1, 1, 32'h103, 32'h000000AB, 0, K_ACK, 0, 32'h0);
        check("bs_be_mem_be", last_be, 4'b0001);
        check("bs_be_wdata", last_wd, 32'hABABABAB);
        check("bs_be_addr", last_addr, 32'h100);

        run_access(1, 1, 32'h103, 32'h000000AB, 1, K_ACK, 1, 32'h0);
        check("bs_le_mem_be", last_be, 4'b1000);

        run_access(0, 1, 32'h101, 32'h0, 0, K_ACK, 0, 32'h11223344);
        check("bl_be_rdata", last_rd, 32'h00000022);

        run_access(0, 0, 32'h102, 32'h0, 0, K_ACK, 0, 32'h12345678);
        check("misaligned_mreq_cycles", mreq_total - mreq0, 0);
        check("misaligned_resp_count", rv_total - rv0, 1);
        check("misaligned_err", last_err, 1);

        run_access(0, 0, 32'h40, 32'h0, 0, K_TO, 0, 32'h0);
        check("timeout_mreq_cycles", mreq_total - mreq0, TO);
        check("timeout_err", last_err, 1);

        run_access(0, 0, 32'h80, 32'h0, 0, K_ACKERR, 1, 32'hDEADBEEF);
        check("ackerr_err", last_err, 1);
        check("ackerr_rdata", last_rd, 32'h0);

        run_access(0, 0, 32'h84, 32'h0, 1, K_ACK, TO - 1, 32'hCAFEF00D);
        check("ack_at_timeout_mreq_cycles", mreq_total - mreq0, TO);
        check("ack_at_timeout_err", last_err, 0);
        check("ack_at_timeout_rdata", last_rd, 32'h0DF0FECA);

        // reset pulsed in the middle of a memory cycle
        set_idle();
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h200;
        req_wdata = 32'h55AA55AA; little_endian_en = 1'b0; mem_ack = 1'b0; memory_error = 1'b0;
        tick();
        req_valid = 1'b0;
        e_ready = 1'b0; e_mreq = 1'b1; e_addr = 32'h200; e_we = 1'b1;
        e_wd = 32'h55AA55AA; e_be = 4'hF;
        tick();
        rv0 = rv_total;
        #2 rst = 1'b0;
        set_idle();
        #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_memory_addr", memory_addr, 0);
        check("rst_mid_data_to_memory", data_to_memory, 0);
        check("rst_mid_mem_be", mem_be, 0);
        check("rst_mid_write_to_memory", write_to_memory, 0);
        check("rst_mid_resp_valid", resp_valid, 0);
        check("rst_mid_resp_error", resp_error, 0);
        check("rst_mid_resp_rdata", resp_rdata, 0);
        mem_ack = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        repeat (5) begin
            junk_mem();
            tick();
        end
        check("rst_mid_no_response", rv_total - rv0, 0);
        check("rst_mid_ready", req_ready, 1);

        for (int i = 0; i < 200; i++) begin
            w    = 1'($urandom % 2);
            b    = 1'($urandom % 2);
            le   = 1'($urandom % 2);
            addr = $urandom;
            if (!b && ($urandom % 4 != 0)) addr[1:0] = 2'b00;
            r    = int'($urandom % 10);
            kind = (r < 6) ? K_ACK : (r == 6) ? K_ERR : (r == 7) ? K_ACKERR : K_TO;
            k    = int'($urandom % TO);
            run_access(w, b, addr, $urandom, le, kind, k, $urandom);
            gap = int'($urandom % 3);
            repeat (gap) begin
                junk_req();
                req_valid = 1'b0;
                junk_mem();
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
